// File: rtl/knn_stream_ctrl.sv
// KNN front-end sequencer: serial-loaded point buffer streamed as
// (test, data) beats to the distance datapath, then flush beats and done.
module knn_stream_ctrl #(
  parameter int DATA_W = 32,
  parameter int NUM_PTS = 128,
  localparam int IDX_W = $clog2(NUM_PTS),
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W:0]    cfg_num_pts,
  input  logic [DATA_W-1:0] test_pt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_test,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_flush,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int CNT_W = IDX_W + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 2);
  localparam logic [FW-1:0] FLAST =
    FW'(FLUSH_CYCLES > 0 ? FLUSH_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  last_idx;
  logic [FW-1:0]     fcnt;
  logic [DATA_W-1:0] mem [NUM_PTS];

  logic              fire;
  logic              addr_ok;
  logic              wr_ok;
  logic              cfg_ok;
  logic [IDX_W-1:0]  nidx;
  logic [DATA_W-1:0] first_data;

  assign fire    = out_valid && out_ready;
  assign addr_ok = {1'b0, wr_addr} < CNT_W'(NUM_PTS);
  assign wr_ok   = wr_en && addr_ok &&
                   (state == IDLE || state == DONE);
  assign cfg_ok  = (cfg_num_pts != '0) &&
                   (cfg_num_pts <= CNT_W'(NUM_PTS));
  assign nidx    = IDX_W'(out_idx + 1'b1);

  // A write landing on entry 0 alongside start must reach the first beat.
  assign first_data = (wr_ok && wr_addr == '0) ? wr_data : mem[0];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_idx  <= '0;
      fcnt      <= '0;
      wr_err    <= 1'b0;
      out_valid <= 1'b0;
      out_test  <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_flush <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      wr_err  <= wr_en && !wr_ok;
      cfg_err <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        fcnt      <= '0;
        out_valid <= 1'b0;
        out_test  <= '0;
        out_data  <= '0;
        out_idx   <= '0;
        out_last  <= 1'b0;
        out_flush <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && cfg_ok) begin
              state     <= STREAM;
              busy      <= 1'b1;
              last_idx  <= IDX_W'(cfg_num_pts - 1'b1);
              out_valid <= 1'b1;
              out_test  <= test_pt;
              out_data  <= first_data;
              out_idx   <= '0;
              out_last  <= (cfg_num_pts == CNT_W'(1));
              out_flush <= 1'b0;
            end else if (start) begin
              cfg_err <= 1'b1;
            end
          end
          STREAM: begin
            if (fire && out_last) begin
              out_test <= '0;
              out_data <= '0;
              out_idx  <= '0;
              out_last <= 1'b0;
              fcnt     <= '0;
              if (FLUSH_CYCLES > 0) begin
                state     <= FLUSH;
                out_flush <= 1'b1;
              end else begin
                state     <= DONE;
                out_valid <= 1'b0;
                done      <= 1'b1;
              end
            end else if (fire) begin
              out_idx  <= nidx;
              out_data <= mem[nidx];
              out_last <= (nidx == last_idx);
            end
          end
          FLUSH: begin
            if (fire && fcnt == FLAST) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_flush <= 1'b0;
              done      <= 1'b1;
            end else if (fire) begin
              fcnt <= FW'(fcnt + 1'b1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_knn_stream_ctrl.sv
// Directed bench for knn_stream_ctrl: vector table per cycle plus
// hand-written sequences for full runs, write/start overlap and reset.
module tb_knn_stream_ctrl;

  localparam int DW = 32;
  localparam int NP = 128;
  localparam int IW = 7;
  localparam logic [31:0] A5 = 32'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_err;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [IW:0]   cfg_num_pts = '0;
  logic [DW-1:0] test_pt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_test;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_flush;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int checks = 0;
  int errors = 0;

  knn_stream_ctrl #(
    .DATA_W(DW),
    .NUM_PTS(NP),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_err(wr_err),
    .start(start),
    .abort(abort),
    .cfg_num_pts(cfg_num_pts),
    .test_pt(test_pt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_test(out_test),
    .out_data(out_data),
    .out_idx(out_idx),
    .out_last(out_last),
    .out_flush(out_flush),
    .busy(busy),
    .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic [IW:0]   cfg;
    logic          rdy;
    logic          ab;
    logic          v;
    logic [IW-1:0] idx;
    logic [DW-1:0] d;
    logic [DW-1:0] t;
    logic          l;
    logic          f;
    logic          dn;
    logic          b;
    logic          ce;
  } vec_t;

  vec_t q[$];

  task automatic row(input logic st, input logic [IW:0] cfg,
                     input logic rdy, input logic ab,
                     input logic v, input logic [IW-1:0] idx,
                     input logic [DW-1:0] d, input logic [DW-1:0] t,
                     input logic l, input logic f, input logic dn,
                     input logic b, input logic ce);
    vec_t r;
    r.st = st; r.cfg = cfg; r.rdy = rdy; r.ab = ab;
    r.v = v; r.idx = idx; r.d = d; r.t = t;
    r.l = l; r.f = f; r.dn = dn; r.b = b; r.ce = ce;
    q.push_back(r);
  endtask

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_addr = IW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  function automatic logic [127:0] outs();
    return {out_valid, out_idx, out_data, out_test,
            out_last, out_flush, done, busy, cfg_err};
  endfunction

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk(name, done, 1'b1);
    tick();
  endtask

  task automatic full_run(input bit inject);
    cfg_num_pts = 8'(NP);
    test_pt = 32'h1234;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NP; i++) begin
      chk("full_beat", {out_valid, out_idx, out_data, out_last},
          {1'b1, IW'(i), ~32'(i), i == NP - 1});
      if (inject && i == 50) begin
        wr_en = 1'b1;
        wr_addr = 7'd5;
        wr_data = 32'h0;
      end
      tick();
      if (inject && i == 50) begin
        wr_en = 1'b0;
        chk("wr_err_stream", wr_err, 1'b1);
      end
    end
    chk("full_flush0", {out_valid, out_flush, out_last}, 3'b110);
    tick();
    chk("full_flush1", {out_valid, out_flush, out_data}, {2'b11, 32'h0});
    tick();
    chk("full_done", {out_valid, done, busy}, 3'b011);
    tick();
    chk("full_idle", {out_valid, done, busy}, 3'b000);
  endtask

  initial begin
    // Nominal run, ready held high.
    row(1, 4, 1, 0, 1, 0, 100, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 1, 101, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 2, 102, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 3, 103, A5, 1, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    row(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Stalled run, ready 1,0,0 repeating.
    row(1, 4, 0, 0, 1, 0, 100, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 1, 101, A5, 0, 0, 0, 1, 0);
    row(0, 0, 0, 0, 1, 1, 101, A5, 0, 0, 0, 1, 0);
    row(0, 0, 0, 0, 1, 1, 101, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 2, 102, A5, 0, 0, 0, 1, 0);
    row(0, 0, 0, 0, 1, 2, 102, A5, 0, 0, 0, 1, 0);
    row(0, 0, 0, 0, 1, 2, 102, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 3, 103, A5, 1, 0, 0, 1, 0);
    row(0, 0, 0, 0, 1, 3, 103, A5, 1, 0, 0, 1, 0);
    row(0, 0, 0, 0, 1, 3, 103, A5, 1, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    row(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Bad configurations.
    row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 129, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Abort on the third beat under stall, then restart.
    row(1, 4, 0, 0, 1, 0, 100, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 1, 101, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 2, 102, A5, 0, 0, 0, 1, 0);
    row(0, 0, 0, 0, 1, 2, 102, A5, 0, 0, 0, 1, 0);
    row(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 4, 0, 0, 1, 0, 100, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 1, 101, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 2, 102, A5, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 3, 103, A5, 1, 0, 0, 1, 0);
    row(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    row(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) tick();
    chk("reset_held", {outs(), wr_err}, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("reset_released", {outs(), wr_err}, '0);

    for (int i = 0; i < 4; i++) wr(i, 32'(100 + i));

    test_pt = A5;
    foreach (q[k]) begin
      start = q[k].st;
      cfg_num_pts = q[k].cfg;
      out_ready = q[k].rdy;
      abort = q[k].ab;
      tick();
      chk($sformatf("vec%0d", k), outs(),
          {q[k].v, q[k].idx, q[k].d, q[k].t,
           q[k].l, q[k].f, q[k].dn, q[k].b, q[k].ce});
    end
    start = 1'b0;
    abort = 1'b0;

    // Write to entry 0 in the same cycle as start.
    wr_en = 1'b1;
    wr_addr = 7'd0;
    wr_data = 32'h777;
    start = 1'b1;
    cfg_num_pts = 8'd1;
    test_pt = 32'h5;
    out_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("wr_start_beat", {out_valid, out_idx, out_data, out_test, out_last},
        {1'b1, 7'd0, 32'h777, 32'h5, 1'b1});
    chk("wr_start_no_err", wr_err, 1'b0);
    wait_done("wr_start_done");

    for (int i = 0; i < NP; i++) wr(i, ~32'(i));
    full_run(1'b1);
    full_run(1'b0);

    // Asynchronous reset in the middle of the flush phase.
    cfg_num_pts = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_flush", {out_valid, out_flush, busy}, 3'b111);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", {outs(), wr_err}, '0);
    @(negedge clk);
    rst = 1'b0;
    test_pt = 32'h9;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_beat", {out_valid, out_idx, out_data, out_test, out_last},
        {1'b1, 7'd0, 32'hFFFF_FFFF, 32'h9, 1'b1});
    wait_done("post_rst_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
